// File: rtl/pkt_write_if.sv
// pkt_write_if: framed ingress stream plus packet-buffer write/rewind port and statistics
interface pkt_write_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int PCK_LEN    = 12
);
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH:0]   wr_lvl;
  logic                  buffer_full;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  out_eop;
  logic [PCK_LEN-1:0]    count;
  logic                  pck_drop;
  logic [PCK_LEN-1:0]    count_w;
  logic                  len_err;
  logic [15:0]           pkt_ok_cnt;
  logic [15:0]           pkt_drop_cnt;
  logic                  busy;
  modport slave (
    input  in_valid, in_sop, in_eop, in_data, wr_lvl, buffer_full,
    output wr_en, wr_data, out_eop, count, pck_drop, count_w, len_err, pkt_ok_cnt, pkt_drop_cnt, busy
  );
  modport master (
    output in_valid, in_sop, in_eop, in_data, wr_lvl, buffer_full,
    input  wr_en, wr_data, out_eop, count, pck_drop, count_w, len_err, pkt_ok_cnt, pkt_drop_cnt, busy
  );
endinterface

// File: rtl/pkt_write_ctrl.sv
// pkt_write_ctrl: validates framed packets against length and buffer space, writes or rewinds the buffer
module pkt_write_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384,
  parameter int ADDR_WIDTH = 14,
  parameter int PCK_LEN    = 12,
  parameter int MIN_PCK    = 2,
  parameter int MAX_PCK    = 4095
) (
  input logic        clk,
  input logic        hw_rst,
  input logic        sw_rst,
  pkt_write_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;
  localparam int SW = ADDR_WIDTH + 2;
  state_t                state_q, state_d;
  logic [PCK_LEN-1:0]    count_q, count_d, len_q, len_d, count_w_q, count_w_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d, out_eop_q, out_eop_d, pck_drop_q, len_err_q, busy_q;
  logic [15:0]           ok_q, ok_d, drop_q, drop_d;
  logic                  abort, reject, good;
  logic [PCK_LEN-1:0]    hdr_len, n;
  logic [SW-1:0]         need;
  logic                  hdr_bad;
  assign hdr_len = bus.in_data[PCK_LEN-1:0];
  assign n       = count_q + PCK_LEN'(1);
  // the write already in flight is not yet reflected in wr_lvl
  assign need    = SW'(hdr_len) + SW'(bus.wr_lvl) + SW'(wr_en_q);
  assign hdr_bad = hdr_len < PCK_LEN'(MIN_PCK) || {1'b0, hdr_len} > (PCK_LEN+1)'(MAX_PCK)
                || need > SW'(DEPTH) || bus.in_eop || bus.buffer_full;
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    out_eop_d = 1'b0;
    abort     = 1'b0;
    reject    = 1'b0;
    good      = 1'b0;
    if (bus.in_valid)
      case (state_q)
        IDLE: if (bus.in_sop) begin
          if (hdr_bad) begin
            reject  = 1'b1;
            state_d = bus.in_eop ? IDLE : DISCARD;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.in_data;
            count_d   = PCK_LEN'(1);
            len_d     = hdr_len;
            state_d   = WRITE;
          end
        end
        WRITE: if (bus.in_sop || ((n == len_q) != bus.in_eop) || bus.buffer_full) begin
          abort   = 1'b1;
          state_d = (bus.in_eop && !bus.in_sop && n != len_q) ? IDLE : DISCARD;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.in_data;
          count_d   = n;
          out_eop_d = bus.in_eop;
          good      = bus.in_eop;
          state_d   = bus.in_eop ? IDLE : WRITE;
        end
        DISCARD: state_d = bus.in_eop ? IDLE : DISCARD;
        default: state_d = IDLE;
      endcase
    count_w_d = abort ? count_q : count_w_q;
    ok_d      = ok_q + 16'(good && ok_q != 16'hFFFF);
    drop_d    = drop_q + 16'((abort || reject) && drop_q != 16'hFFFF);
  end
  always_ff @(posedge clk or posedge hw_rst)
    if (hw_rst || sw_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      len_q      <= '0;
      count_w_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      out_eop_q  <= 1'b0;
      pck_drop_q <= 1'b0;
      len_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      ok_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      count_w_q  <= count_w_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      out_eop_q  <= out_eop_d;
      pck_drop_q <= abort;
      len_err_q  <= abort || reject;
      busy_q     <= state_d != IDLE;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
    end
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.out_eop      = out_eop_q;
  assign bus.count        = count_q;
  assign bus.pck_drop     = pck_drop_q;
  assign bus.count_w      = count_w_q;
  assign bus.len_err      = len_err_q;
  assign bus.pkt_ok_cnt   = ok_q;
  assign bus.pkt_drop_cnt = drop_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_pkt_write_ctrl.sv
// tb_pkt_write_ctrl: directed vector table, hand sequences and random traffic against a packet-level model
module tb_pkt_write_ctrl;
  logic clk = 1'b0, hw_rst = 1'b1, sw_rst = 1'b0;
  always #5 clk = ~clk;
  pkt_write_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .PCK_LEN(12)) bus ();
  pkt_write_ctrl dut (.clk(clk), .hw_rst(hw_rst), .sw_rst(sw_rst), .bus(bus));
  int tests = 0, fails = 0;
  typedef struct {
    logic v, s, e, full;
    logic [31:0] d;
    int lvl;
    logic [4:0] flags;
    logic [11:0] cnt, cw;
    logic [15:0] ok, dr;
  } vec_t;
  vec_t tq[$];
  int mode, plen;
  logic [31:0] acc[$];
  logic e_we, e_eop, e_drop, e_err, e_busy;
  logic [31:0] e_data;
  logic [11:0] e_cnt, e_cw;
  logic [15:0] e_ok, e_dr;
  function automatic logic [60:0] act_vec();
    return {bus.wr_en, bus.out_eop, bus.pck_drop, bus.len_err, bus.busy,
            bus.count, bus.count_w, bus.pkt_ok_cnt, bus.pkt_drop_cnt};
  endfunction
  function automatic logic [60:0] exp_vec();
    return {e_we, e_eop, e_drop, e_err, e_busy, e_cnt, e_cw, e_ok, e_dr};
  endfunction
  function automatic logic [15:0] sat(input logic [15:0] x);
    return x == 16'hFFFF ? x : x + 16'd1;
  endfunction
  task automatic check(input string name, input logic [60:0] a, input logic [60:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic check_data(input string name, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s wr_data: got %h expected %h", name, a, e);
    end
  endtask
  task automatic drive(input logic v, s, e, input logic [31:0] d, input int lvl, input logic full);
    bus.in_valid = v; bus.in_sop = s; bus.in_eop = e; bus.in_data = d;
    bus.wr_lvl = 15'(lvl); bus.buffer_full = full;
  endtask
  task automatic model_reset();
    mode = 0; plen = 0; acc.delete();
    {e_we, e_eop, e_drop, e_err, e_busy} = '0;
    e_data = '0; e_cnt = '0; e_cw = '0; e_ok = '0; e_dr = '0;
  endtask
  // packet-level view: acc holds the words of the packet currently being stored
  task automatic model_step(input logic v, s, e, input logic [31:0] d, input int lvl, input logic full);
    int n;
    logic pw;
    pw = e_we;
    {e_we, e_eop, e_drop, e_err} = '0;
    if (v) begin
      if (mode == 0) begin
        if (s) begin
          plen = int'(d[11:0]);
          if (e || plen < 2 || plen > 4095 || plen > 16384 - lvl - int'(pw) || full) begin
            e_err = 1; e_dr = sat(e_dr); mode = e ? 0 : 2;
          end else begin
            acc.delete(); acc.push_back(d);
            e_we = 1; e_data = d; e_cnt = 12'(acc.size()); mode = 1;
          end
        end
      end else if (mode == 1) begin
        n = acc.size() + 1;
        if (!s && e && n == plen && !full) begin
          acc.push_back(d);
          e_we = 1; e_data = d; e_cnt = 12'(acc.size()); e_eop = 1; e_ok = sat(e_ok); mode = 0;
        end else if (s || e || n == plen || full) begin
          e_drop = 1; e_err = 1; e_cw = 12'(acc.size()); e_dr = sat(e_dr);
          mode = (e && !s && n != plen) ? 0 : 2;
          acc.delete();
        end else begin
          acc.push_back(d);
          e_we = 1; e_data = d; e_cnt = 12'(acc.size());
        end
      end else if (e) mode = 0;
    end
    e_busy = mode != 0;
  endtask
  task automatic step(input string name, input logic v, s, e, input logic [31:0] d, input int lvl, input logic full);
    drive(v, s, e, d, lvl, full);
    model_step(v, s, e, d, lvl, full);
    @(posedge clk); #1;
    check(name, act_vec(), exp_vec());
    if (e_we) check_data(name, bus.wr_data, e_data);
  endtask
  task automatic do_hw_reset();
    drive(0, 0, 0, 0, 0, 0);
    hw_rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    hw_rst = 1'b0;
    check("hw_rst", act_vec(), exp_vec());
  endtask
  function automatic void add(input logic v, s, e, input logic [31:0] d, input int lvl, input logic full,
                              input logic [4:0] f, input logic [11:0] c, cw, input logic [15:0] ok, dr);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.d = d; t.lvl = lvl; t.full = full;
    t.flags = f; t.cnt = c; t.cw = cw; t.ok = ok; t.dr = dr;
    tq.push_back(t);
  endfunction
  initial begin
    // flags: {wr_en, out_eop, pck_drop, len_err, busy}
    add(1,1,0,32'd4,0,0,         5'b10001,1,0,0,0);
    add(1,0,0,32'hA1,0,0,        5'b10001,2,0,0,0);
    add(1,0,0,32'hA2,0,0,        5'b10001,3,0,0,0);
    add(1,0,1,32'hA3,0,0,        5'b11000,4,0,1,0);
    add(1,1,0,32'd6,0,0,         5'b10001,1,0,1,0);
    add(1,0,0,32'hB1,0,0,        5'b10001,2,0,1,0);
    add(1,0,1,32'hB2,0,0,        5'b00110,2,2,1,1);
    add(0,0,0,32'h0,0,0,         5'b00000,2,2,1,1);
    add(1,1,0,32'd3,16382,0,     5'b00011,2,2,1,2);
    add(1,0,0,32'hC1,16382,0,    5'b00001,2,2,1,2);
    add(1,0,1,32'hC2,16382,0,    5'b00000,2,2,1,2);
    add(1,1,0,32'd3,16381,0,     5'b10001,1,2,1,2);
    add(1,0,0,32'hD1,16381,0,    5'b10001,2,2,1,2);
    add(1,0,1,32'hD2,16381,0,    5'b11000,3,2,2,2);
    add(1,1,1,32'd2,0,0,         5'b00010,3,2,2,3);
    add(1,1,0,32'd5,0,0,         5'b10001,1,2,2,3);
    add(1,0,0,32'hE1,0,0,        5'b10001,2,2,2,3);
    add(1,1,0,32'd4,0,0,         5'b00111,2,2,2,4);
    add(1,0,0,32'hE2,0,0,        5'b00001,2,2,2,4);
    add(1,0,1,32'hE3,0,0,        5'b00000,2,2,2,4);
    add(1,1,0,32'd3,0,0,         5'b10001,1,2,2,4);
    add(1,0,0,32'hF1,0,0,        5'b10001,2,2,2,4);
    add(1,0,0,32'hF2,0,0,        5'b00111,2,2,2,5);
    add(1,0,0,32'hF3,0,0,        5'b00001,2,2,2,5);
    add(1,0,1,32'hF4,0,0,        5'b00000,2,2,2,5);
    add(1,1,0,32'd2,0,0,         5'b10001,1,2,2,5);
    add(1,0,1,32'hA7,0,0,        5'b11000,2,2,3,5);
    add(1,1,0,32'd1,0,0,         5'b00011,2,2,3,6);
    add(1,0,1,32'hA8,0,0,        5'b00000,2,2,3,6);
    add(1,1,0,32'd2,0,0,         5'b10001,1,2,3,6);
    add(1,0,1,32'hA9,0,0,        5'b11000,2,2,4,6);
    add(1,1,0,32'd3,16381,0,     5'b00011,2,2,4,7);
    add(1,0,1,32'hAA,16381,0,    5'b00000,2,2,4,7);
    add(1,1,0,32'd3,0,0,         5'b10001,1,2,4,7);
    add(1,0,0,32'hAB,0,1,        5'b00111,1,1,4,8);
    add(1,0,1,32'hAC,0,0,        5'b00000,1,1,4,8);
    do_hw_reset();
    foreach (tq[i]) begin
      drive(tq[i].v, tq[i].s, tq[i].e, tq[i].d, tq[i].lvl, tq[i].full);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), act_vec(),
            {tq[i].flags, tq[i].cnt, tq[i].cw, tq[i].ok, tq[i].dr});
      if (tq[i].flags[4]) check_data($sformatf("vec%0d", i), bus.wr_data, tq[i].d);
    end
    // bubbles, then software reset mid-packet
    do_hw_reset();
    step("bub_hdr", 1, 1, 0, 32'd4, 0, 0);
    step("bub_gap", 0, 0, 0, 32'h0, 0, 0);
    step("bub_w2",  1, 0, 0, 32'h55, 0, 0);
    for (int g = 0; g < 3; g++) step("bub_gap", 0, 0, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 32'h66, 0, 0);
    sw_rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    sw_rst = 1'b0;
    check("sw_rst", act_vec(), exp_vec());
    step("post_sw_ign", 1, 0, 1, 32'h77, 0, 0);
    step("post_sw_hdr", 1, 1, 0, 32'd2, 0, 0);
    step("post_sw_eop", 1, 0, 1, 32'h88, 0, 0);
    // random traffic
    do_hw_reset();
    for (int k = 0; k < 3000; k++) begin
      logic v, s, e, full;
      logic [31:0] d;
      int lvl;
      v = $urandom_range(0, 3) != 0;
      s = $urandom_range(0, 5) == 0;
      e = $urandom_range(0, 4) == 0;
      d = $urandom;
      if (s) d[11:0] = 12'($urandom_range(0, 9));
      lvl = $urandom_range(0, 3) == 0 ? int'($urandom_range(16376, 16384)) : int'($urandom_range(0, 16000));
      full = $urandom_range(0, 31) == 0;
      step("rand", v, s, e, d, lvl, full);
    end
    // drop counter saturation with single-word rejects
    do_hw_reset();
    for (int k = 0; k < 65540; k++) step("sat", 1, 1, 1, 32'd2, 0, 0);
    check("sat_final", act_vec(), {5'b00010, 12'd0, 12'd0, 16'd0, 16'hFFFF});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pkt_write_ctrl.md
Name: pkt_write_ctrl

Overview:
- Ingress stage directly upstream of the packet buffer. Accepts a framed word stream (sop/eop/valid) whose header word carries the packet length.
- Checks framing, length and buffer space. Writes accepted words into the buffer through its wr_en/wr_data/in_eop/count interface.
- On a mid-packet error, rewinds the buffer with pck_drop/count_w.
- Maintains saturating accept/drop statistics counters.

Parameters:
DATA_WIDTH, 32, stream/buffer word width
DEPTH, 16384, buffer depth in words
ADDR_WIDTH, 14, log2(DEPTH); wr_lvl is ADDR_WIDTH+1 bits
PCK_LEN, 12, width of length/count fields
MIN_PCK, 2, minimum legal packet length in words (header included)
MAX_PCK, 4095, maximum legal packet length in words

Ports:
clk  in  1  clock
hw_rst  in  1  reset, asynchronous, active-high
sw_rst  in  1  synchronous software reset, active-high, same effect as hw_rst
in_valid  in  1  input word valid
in_sop  in  1  first word of packet (header), qualified by in_valid
in_eop  in  1  last word of packet, qualified by in_valid
in_data  in  DATA_WIDTH  input word; on sop, in_data[PCK_LEN-1:0] = total length in words
wr_lvl  in  ADDR_WIDTH+1  buffer fill level
buffer_full  in  1  buffer full flag
wr_en  out  1  buffer write strobe
wr_data  out  DATA_WIDTH  buffer write data
out_eop  out  1  last word of an accepted packet; drives buffer in_eop
count  out  PCK_LEN  words of current packet written so far, including the word on wr_en
pck_drop  out  1  one-cycle rewind request to the buffer
count_w  out  PCK_LEN  words to rewind; valid with pck_drop
len_err  out  1  one-cycle pulse on any rejected packet
pkt_ok_cnt  out  16  accepted packets, saturating
pkt_drop_cnt  out  16  rejected packets, saturating
busy  out  1  state != IDLE

Behaviour:
- All outputs are registered. Reset value is 0 for every output and for the state register (IDLE).
- Latency: an input word appears on wr_en/wr_data one cycle after the in_valid cycle.
- Only valid cycles advance the FSM. in_valid=0 holds state and produces wr_en=0.
- States are IDLE, WRITE and DISCARD.
- IDLE, in_valid and no in_sop: word ignored, stay IDLE.
- IDLE, in_valid and in_sop: L = in_data[PCK_LEN-1:0]. Reject when any of:
  - L < MIN_PCK
  - L > MAX_PCK
  - L > DEPTH - wr_lvl - wr_en (the registered write in flight)
  - in_eop is set on the same word
- On reject from IDLE: nothing is written, no pck_drop, len_err=1, pkt_drop_cnt+1. Go to DISCARD, or stay IDLE if in_eop was set.
- On accept from IDLE: write the header, count=1, latch L, go to WRITE.
- WRITE, in_valid, let n = count+1:
  - in_sop: error. Word not written; pck_drop=1, count_w=count; go to DISCARD (the new packet is discarded up to its eop).
  - in_eop and n==L: write, out_eop=1, count=n, pkt_ok_cnt+1, go to IDLE.
  - in_eop and n!=L: word not written; pck_drop=1, count_w=count; go to IDLE.
  - no eop and n==L: word not written; pck_drop=1, count_w=count; go to DISCARD.
  - otherwise: write, count=n.
- Every pck_drop also produces len_err=1 and pkt_drop_cnt+1.
- DISCARD: consume valid words without writing. in_eop returns to IDLE. A word with in_sop and in_eop together also returns to IDLE. A word with in_sop alone stays in DISCARD.
- wr_en and pck_drop are never high in the same cycle. The buffer therefore never sees a combined rewind and write.
- count_w always equals the number of words of the aborted packet already issued on wr_en.
- Space is reserved at header time and this block is the only writer, so buffer_full cannot occur mid-packet.
- Defensive rule: if buffer_full=1 when a write would issue, treat it as an error. Word not written; pck_drop with count_w=count; go to DISCARD.
- wr_en is never asserted while buffer_full=1, so the buffer's overflow never fires due to this block.
- count holds its value between packets and loads 1 on every accepted header.
- Statistics counters saturate at 16'hFFFF and clear only on reset.
- Reset mid-packet (hw_rst or sw_rst) returns to IDLE with all outputs 0 and issues no pck_drop. The buffer is reset by the same resets.
- Arithmetic: the space check is done at ADDR_WIDTH+2 bits to avoid wrap. Length compares are done at PCK_LEN bits.

Test Plan:
- Good packet: sop L=4, 4 words back-to-back, eop on word 4 -> wr_en high for 4 cycles starting 1 cycle later; count 1,2,3,4; out_eop on 4th; pkt_ok_cnt=1.
- Short eop: L=6, eop on word 3 -> 2 writes, then pck_drop=1 with count_w=2, len_err=1, no 3rd write, state IDLE, pkt_drop_cnt=1.
- Overlong packet: L=3, words continue past 3 with no eop -> 2 writes; pck_drop with count_w=2 on the 3rd word; DISCARD until eop; next packet accepted normally.
- Space reject: wr_lvl=16382, header L=3 -> no writes, no pck_drop, len_err=1, DISCARD to eop. Repeat with wr_lvl=16381 -> packet accepted.
- Early sop: L=5, sop on word 3 -> pck_drop with count_w=2, then that second packet is discarded to its eop. Also cover sop+eop single word in IDLE -> rejected, stays IDLE.
- Bubbles and reset: L=4 with in_valid gaps of 1-3 cycles -> writes track valid words only. Assert sw_rst after 2 writes -> all outputs 0, IDLE, no pck_drop.
